// File: rtl/commit_rdctrl_if.sv
// Signal bundle between commit, the read controller, memory read channel and load buffer.
// The controller uses the slave view; commit/memory/load-buffer models use the master view.
interface commit_rdctrl_if;
  logic        rdctrl_en;
  logic [7:0]  rdctrl_fid;
  logic [31:0] rdctrl_addr;
  logic        rdctrl_uncached;
  logic [1:0]  rdctrl_lswidth;
  logic        rdctrl_readyn;

  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rlast;
  logic        mem_rready;

  logic        lb_wen;
  logic [31:0] lb_addr;
  logic [31:0] lb_data;
  logic        lb_done;
  logic [7:0]  lb_fid;
  logic        busy;

  modport slave (
    input  rdctrl_en, rdctrl_fid, rdctrl_addr, rdctrl_uncached, rdctrl_lswidth,
    output rdctrl_readyn,
    output mem_arvalid, mem_araddr, mem_arlen, mem_rready,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rlast,
    output lb_wen, lb_addr, lb_data, lb_done, lb_fid, busy
  );

  modport master (
    output rdctrl_en, rdctrl_fid, rdctrl_addr, rdctrl_uncached, rdctrl_lswidth,
    input  rdctrl_readyn,
    input  mem_arvalid, mem_araddr, mem_arlen, mem_rready,
    output mem_arready, mem_rvalid, mem_rdata, mem_rlast,
    input  lb_wen, lb_addr, lb_data, lb_done, lb_fid, busy
  );
endinterface

// File: rtl/commit_rdctrl.sv
// Load-miss read controller: queues commit read requests, issues them one at a time on the
// memory read channel and streams returned words into the load buffer.
module commit_rdctrl #(
  parameter int LINE_WORDS = 4,
  parameter int QDEPTH     = 2
) (
  input  logic            clk,
  input  logic            reset,
  commit_rdctrl_if.slave  bus
);

  localparam int          QW         = $clog2(QDEPTH);
  localparam int          BW         = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_MASK  = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [7:0]  ARLEN_LINE = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t          state, state_nxt;

  logic [31:0]     q_addr [QDEPTH];
  logic [7:0]      q_fid  [QDEPTH];
  logic            q_unc  [QDEPTH];
  logic [QDEPTH-1:0] q_vld;
  logic [QW-1:0]   wr_ptr, rd_ptr;
  logic [QW:0]     count, count_nxt;
  logic            readyn;

  logic [31:0]     cur_addr;
  logic [7:0]      cur_fid;
  logic            cur_unc;
  logic [BW-1:0]   beat;

  logic [31:0]     enq_addr;
  logic            dup, push, pop, beat_fire;

  // Request intake: align, detect duplicate lines, decide enqueue
  always_comb begin
    enq_addr = bus.rdctrl_uncached ? (bus.rdctrl_addr & ~32'd3)
                                   : (bus.rdctrl_addr & LINE_MASK);
    dup = 1'b0;
    if (!bus.rdctrl_uncached) begin
      if (state != S_IDLE && !cur_unc && cur_addr == enq_addr) dup = 1'b1;
      for (int i = 0; i < QDEPTH; i++)
        if (q_vld[i] && !q_unc[i] && q_addr[i] == enq_addr) dup = 1'b1;
    end
    push      = bus.rdctrl_en && !readyn && !dup;
    pop       = (state == S_IDLE) && (count != '0);
    beat_fire = (state == S_DATA) && bus.mem_rvalid;
    count_nxt = count + (QW+1)'(push) - (QW+1)'(pop);
  end

  // Queue storage and in-flight entry; payload only, qualified by q_vld/state
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= enq_addr;
      q_fid[wr_ptr]  <= bus.rdctrl_fid;
      q_unc[wr_ptr]  <= bus.rdctrl_uncached;
    end
    if (pop) begin
      cur_addr <= q_addr[rd_ptr];
      cur_fid  <= q_fid[rd_ptr];
      cur_unc  <= q_unc[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
      readyn <= 1'b0;
      beat   <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + QW'(1);
        q_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + QW'(1);
        q_vld[rd_ptr] <= 1'b0;
      end
      count  <= count_nxt;
      readyn <= (count_nxt == (QW+1)'(QDEPTH));
      if (pop)            beat <= '0;
      else if (beat_fire) beat <= beat + BW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state; rlast ends the burst regardless of beat count
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (count != '0)                          state_nxt = S_ADDR;
      S_ADDR: if (bus.mem_arready)                      state_nxt = S_DATA;
      S_DATA: if (bus.mem_rvalid && bus.mem_rlast)      state_nxt = S_DONE;
      S_DONE:                                           state_nxt = S_IDLE;
      default:                                          state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; payload fields are zeroed outside their qualifying state
  always_comb begin
    bus.rdctrl_readyn = readyn;
    bus.mem_arvalid   = (state == S_ADDR);
    bus.mem_araddr    = '0;
    bus.mem_arlen     = '0;
    if (state == S_ADDR) begin
      bus.mem_araddr = cur_addr;
      bus.mem_arlen  = cur_unc ? 8'd0 : ARLEN_LINE;
    end
    bus.mem_rready = (state == S_DATA);
    bus.lb_wen     = beat_fire;
    bus.lb_addr    = '0;
    bus.lb_data    = '0;
    if (beat_fire) begin
      bus.lb_addr = cur_addr + {{(30-BW){1'b0}}, beat, 2'b00};
      bus.lb_data = bus.mem_rdata;
    end
    bus.lb_done = (state == S_DONE);
    bus.lb_fid  = (state == S_DONE) ? cur_fid : 8'd0;
    bus.busy    = (count != '0) || (state != S_IDLE);
  end

endmodule

// File: tb/tb_commit_rdctrl.sv
// Directed bench for commit_rdctrl: cycle table for single transactions, hand sequences for
// queue-full, duplicate drop and mid-transaction reset.
module tb_commit_rdctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  commit_rdctrl_if bus();

  commit_rdctrl #(.LINE_WORDS(4), .QDEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        readyn;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rready;
    logic        lb_wen;
    logic [31:0] lb_addr;
    logic [31:0] lb_data;
    logic        lb_done;
    logic [7:0]  lb_fid;
    logic        busy;
  } out_t;

  typedef struct packed {
    logic        en;
    logic [7:0]  fid;
    logic [31:0] addr;
    logic        unc;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    out_t        exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt[$];

  function automatic out_t e_idle(logic b);
    out_t o = '0;
    o.busy = b;
    return o;
  endfunction

  function automatic out_t e_addr(logic [31:0] a, logic [7:0] len);
    out_t o = '0;
    o.arvalid = 1'b1; o.araddr = a; o.arlen = len; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t e_beat(logic [31:0] a, logic [31:0] d);
    out_t o = '0;
    o.rready = 1'b1; o.lb_wen = 1'b1; o.lb_addr = a; o.lb_data = d; o.busy = 1'b1;
    return o;
  endfunction

  function automatic out_t e_done(logic [7:0] f);
    out_t o = '0;
    o.lb_done = 1'b1; o.lb_fid = f; o.busy = 1'b1;
    return o;
  endfunction

  function automatic vec_t rq(logic [7:0] f, logic [31:0] a, logic u, out_t e);
    vec_t v = '0;
    v.en = 1'b1; v.fid = f; v.addr = a; v.unc = u; v.exp = e;
    return v;
  endfunction

  function automatic vec_t mm(logic ar, logic rv, logic [31:0] d, logic rl, out_t e);
    vec_t v = '0;
    v.arready = ar; v.rvalid = rv; v.rdata = d; v.rlast = rl; v.exp = e;
    return v;
  endfunction

  function automatic out_t cap();
    out_t o;
    o.readyn  = bus.rdctrl_readyn;
    o.arvalid = bus.mem_arvalid;
    o.araddr  = bus.mem_araddr;
    o.arlen   = bus.mem_arlen;
    o.rready  = bus.mem_rready;
    o.lb_wen  = bus.lb_wen;
    o.lb_addr = bus.lb_addr;
    o.lb_data = bus.lb_data;
    o.lb_done = bus.lb_done;
    o.lb_fid  = bus.lb_fid;
    o.busy    = bus.busy;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input out_t exp);
    out_t got;
    got = cap();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic e, input logic [7:0] f, input logic [31:0] a, input logic u);
    bus.rdctrl_en = e; bus.rdctrl_fid = f; bus.rdctrl_addr = a; bus.rdctrl_uncached = u;
  endtask

  // Wait for an AR, accept it, return nb beats (rlast on the final one), then expect lb_done
  task automatic serve(input logic [31:0] a, input logic [7:0] len, input int nb,
                       input logic [7:0] f);
    int n = 0;
    while (bus.mem_arvalid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("ar_seen", 32'(bus.mem_arvalid), 32'd1);
    if (bus.mem_arvalid !== 1'b1) return;
    chk("araddr", bus.mem_araddr, a);
    chk("arlen", 32'(bus.mem_arlen), 32'(len));
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hB000_0000 | 32'(f) << 8 | 32'(b);
      bus.mem_rlast  = (b == nb - 1);
      #1;
      chk("beat_wen", 32'(bus.lb_wen), 32'd1);
      chk("beat_addr", bus.lb_addr, a + 32'(4 * b));
      chk("beat_data", bus.lb_data, 32'hB000_0000 | 32'(f) << 8 | 32'(b));
      tick();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    #1;
    chk("done", 32'(bus.lb_done), 32'd1);
    chk("done_fid", 32'(bus.lb_fid), 32'(f));
    tick();
  endtask

  initial begin
    logic saw_ar, saw_done;

    req(1'b0, 8'h00, 32'h0, 1'b0);
    bus.rdctrl_lswidth = 2'd2;
    bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_rlast = 1'b0;

    // Cached line fetch, arready immediately
    vt.push_back(rq(8'h11, 32'h0000_1234, 1'b0, e_idle(1'b0)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_idle(1'b1)));
    vt.push_back(mm(1'b1, 1'b0, 32'h0, 1'b0, e_addr(32'h0000_1230, 8'd3)));
    vt.push_back(mm(1'b0, 1'b1, 32'hD000_0000, 1'b0, e_beat(32'h0000_1230, 32'hD000_0000)));
    vt.push_back(mm(1'b0, 1'b1, 32'hD000_0001, 1'b0, e_beat(32'h0000_1234, 32'hD000_0001)));
    vt.push_back(mm(1'b0, 1'b1, 32'hD000_0002, 1'b0, e_beat(32'h0000_1238, 32'hD000_0002)));
    vt.push_back(mm(1'b0, 1'b1, 32'hD000_0003, 1'b1, e_beat(32'h0000_123C, 32'hD000_0003)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_done(8'h11)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_idle(1'b0)));
    // Uncached single word
    vt.push_back(rq(8'h22, 32'hA000_0007, 1'b1, e_idle(1'b0)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_idle(1'b1)));
    vt.push_back(mm(1'b1, 1'b0, 32'h0, 1'b0, e_addr(32'hA000_0004, 8'd0)));
    vt.push_back(mm(1'b0, 1'b1, 32'h5555_AAAA, 1'b1, e_beat(32'hA000_0004, 32'h5555_AAAA)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_done(8'h22)));
    // rvalid in IDLE is ignored
    vt.push_back(mm(1'b0, 1'b1, 32'hFFFF_0000, 1'b1, e_idle(1'b0)));
    // Early rlast on beat 2 of 4, then a request queued during DONE
    vt.push_back(rq(8'h33, 32'h0000_2000, 1'b0, e_idle(1'b0)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_idle(1'b1)));
    vt.push_back(mm(1'b1, 1'b0, 32'h0, 1'b0, e_addr(32'h0000_2000, 8'd3)));
    vt.push_back(mm(1'b0, 1'b1, 32'hE000_0000, 1'b0, e_beat(32'h0000_2000, 32'hE000_0000)));
    vt.push_back(mm(1'b0, 1'b1, 32'hE000_0001, 1'b1, e_beat(32'h0000_2004, 32'hE000_0001)));
    vt.push_back(rq(8'h34, 32'h0000_2010, 1'b0, e_done(8'h33)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_idle(1'b1)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_addr(32'h0000_2010, 8'd3)));
    vt.push_back(mm(1'b1, 1'b0, 32'h0, 1'b0, e_addr(32'h0000_2010, 8'd3)));
    vt.push_back(mm(1'b0, 1'b1, 32'hE000_0002, 1'b1, e_beat(32'h0000_2010, 32'hE000_0002)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_done(8'h34)));
    vt.push_back(mm(1'b0, 1'b0, 32'h0, 1'b0, e_idle(1'b0)));

    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_state", '0);
    reset = 1'b0;
    #1;
    chk_out("after_reset", '0);

    foreach (vt[i]) begin
      tick();
      req(vt[i].en, vt[i].fid, vt[i].addr, vt[i].unc);
      bus.mem_arready = vt[i].arready;
      bus.mem_rvalid  = vt[i].rvalid;
      bus.mem_rdata   = vt[i].rdata;
      bus.mem_rlast   = vt[i].rlast;
      @(negedge clk);
      chk_out($sformatf("row%0d", i), vt[i].exp);
    end

    // Queue fills while the first request stalls in ADDR
    tick();
    req(1'b0, 8'h00, 32'h0, 1'b0);
    bus.mem_arready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rlast = 1'b0;
    req(1'b1, 8'h41, 32'h0000_3000, 1'b0); tick();
    req(1'b1, 8'h42, 32'h0000_4000, 1'b0); tick();
    req(1'b1, 8'h43, 32'h0000_5000, 1'b0); #1;
    chk("fill_readyn0", 32'(bus.rdctrl_readyn), 32'd0);
    chk("fill_arvalid", 32'(bus.mem_arvalid), 32'd1);
    tick();
    req(1'b1, 8'h44, 32'h0000_6000, 1'b0); #1;
    chk("full_readyn", 32'(bus.rdctrl_readyn), 32'd1);
    tick();
    req(1'b0, 8'h00, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_arvalid", 32'(bus.mem_arvalid), 32'd1);
      chk("stall_araddr", bus.mem_araddr, 32'h0000_3000);
      chk("stall_arlen", 32'(bus.mem_arlen), 32'd3);
      tick();
    end
    serve(32'h0000_3000, 8'd3, 4, 8'h41);
    serve(32'h0000_4000, 8'd3, 4, 8'h42);
    serve(32'h0000_5000, 8'd3, 4, 8'h43);
    repeat (5) tick();
    chk("no_4th_ar", 32'(bus.mem_arvalid), 32'd0);
    chk("fill_idle", 32'(bus.busy), 32'd0);

    // Duplicate cached line dropped, repeated uncached kept
    req(1'b1, 8'h51, 32'h0000_7000, 1'b0); tick();
    req(1'b0, 8'h00, 32'h0, 1'b0); tick();
    req(1'b1, 8'h52, 32'h0000_7008, 1'b0); #1;
    chk("dup_accepted", 32'(bus.rdctrl_readyn), 32'd0);
    tick();
    req(1'b1, 8'h53, 32'h0000_7004, 1'b1); tick();
    req(1'b1, 8'h54, 32'h0000_7004, 1'b1); #1;
    chk("dup_not_counted", 32'(bus.rdctrl_readyn), 32'd0);
    tick();
    req(1'b0, 8'h00, 32'h0, 1'b0); #1;
    chk("unc_both_queued", 32'(bus.rdctrl_readyn), 32'd1);
    serve(32'h0000_7000, 8'd3, 4, 8'h51);
    serve(32'h0000_7004, 8'd0, 1, 8'h53);
    serve(32'h0000_7004, 8'd0, 1, 8'h54);
    repeat (5) tick();
    chk("no_dup_ar", 32'(bus.mem_arvalid), 32'd0);
    chk("dup_idle", 32'(bus.busy), 32'd0);

    // Reset during DATA beat 1 with a second request queued
    req(1'b1, 8'h61, 32'h0000_8000, 1'b0); tick();
    req(1'b1, 8'h62, 32'h0000_9000, 1'b0); tick();
    req(1'b0, 8'h00, 32'h0, 1'b0);
    bus.mem_arready = 1'b1; #1;
    chk("rst_seq_ar", 32'(bus.mem_arvalid), 32'd1);
    tick();
    bus.mem_arready = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC000_0000; bus.mem_rlast = 1'b0; #1;
    chk("rst_seq_b0", bus.lb_addr, 32'h0000_8000);
    tick();
    bus.mem_rdata = 32'hC000_0001; #1;
    chk("rst_seq_b1", bus.lb_addr, 32'h0000_8004);
    #2 reset = 1'b1;
    #1;
    chk_out("mid_reset_outputs", '0);
    bus.mem_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    saw_ar = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.mem_arvalid === 1'b1) saw_ar = 1'b1;
      if (bus.lb_done === 1'b1) saw_done = 1'b1;
      tick();
    end
    chk("no_done_after_rst", 32'(saw_done), 32'd0);
    chk("queue_flushed", 32'(saw_ar), 32'd0);
    chk("rst_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
